// File: rtl/regbank_pkg.sv
// Shared constants and slice helper for the register bank storage.
package regbank_pkg;
  localparam int REG_COUNT  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int BUS_WIDTH  = REG_COUNT * DATA_WIDTH;
  localparam int ZERO_IDX   = 0;

  function automatic int slice_base(input int idx);
    return idx * DATA_WIDTH;
  endfunction
endpackage

// File: rtl/regbank_dec5to32.sv
// 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module dec5to32 import regbank_pkg::*; (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] idx,
  output logic [REG_COUNT-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/regbank_store.sv
// Architectural register storage with pending-write scoreboard and ID stall.
// Optional same-cycle writeback forwarding via macro REGBANK_BYPASS_EN.
module regbank_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   RegWrite,
  input  logic [ADDR_WIDTH-1:0]                  WriteRegister,
  input  logic [DATA_WIDTH-1:0]                  WriteData,
  input  logic                                   IssueValid,
  input  logic [ADDR_WIDTH-1:0]                  IssueDest,
  input  logic [ADDR_WIDTH-1:0]                  ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]                  ReadRegister2,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  RegBus,
  output logic [2**ADDR_WIDTH-1:0]               Busy,
  output logic                                   Stall
);
  import regbank_pkg::*;

  localparam int NREG = 2**ADDR_WIDTH;
  // Register 0 is excluded from both storage writes and the scoreboard when hardwired.
  localparam logic [NREG-1:0] KEEP = (ZERO_REG != 0) ? ~(NREG'(1) << ZERO_IDX) : '1;

  logic [NREG-1:0]       wr_hot, iss_hot, wr_hit, iss_hit, busy_eff;
  logic [DATA_WIDTH-1:0] regs [NREG];

  dec5to32 u_dec_wr (
    .en     (RegWrite),
    .idx    (WriteRegister),
    .onehot (wr_hot)
  );

  dec5to32 u_dec_iss (
    .en     (IssueValid),
    .idx    (IssueDest),
    .onehot (iss_hot)
  );

  assign wr_hit  = wr_hot & KEEP;
  assign iss_hit = iss_hot & KEEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wr_hit[i]) regs[i] <= WriteData;
    end
  end

  // Set after clear so a newer producer issued on the writeback edge keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) Busy <= '0;
    else       Busy <= (Busy & ~wr_hit) | iss_hit;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_slice
`ifdef REGBANK_BYPASS_EN
    assign RegBus[i*DATA_WIDTH +: DATA_WIDTH] = wr_hit[i] ? WriteData : regs[i];
`else
    assign RegBus[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
`endif
  end

`ifdef REGBANK_BYPASS_EN
  assign busy_eff = Busy & ~wr_hit;
`else
  assign busy_eff = Busy;
`endif

  assign Stall = busy_eff[ReadRegister1] | busy_eff[ReadRegister2];
endmodule

// File: tb/tb_regbank_store.sv
// Self-checking bench for regbank_store: directed table, corner sequences, random vs model.
module tb_regbank_store;
  import regbank_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          RegWrite = 1'b0;
  logic [4:0]    WriteRegister = '0;
  logic [31:0]   WriteData = '0;
  logic          IssueValid = 1'b0;
  logic [4:0]    IssueDest = '0;
  logic [4:0]    ReadRegister1 = '0;
  logic [4:0]    ReadRegister2 = '0;
  logic [1023:0] RegBus;
  logic [31:0]   Busy;
  logic          Stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regbank_store dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .IssueValid    (IssueValid),
    .IssueDest     (IssueDest),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .RegBus        (RegBus),
    .Busy          (Busy),
    .Stall         (Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one rising edge.
  task automatic model_edge();
    if (RegWrite && WriteRegister != 0) m_regs[WriteRegister] = WriteData;
    if (RegWrite) m_busy[WriteRegister] = 1'b0;
    if (IssueValid && IssueDest != 0) m_busy[IssueDest] = 1'b1;
  endtask

  function automatic logic [1023:0] exp_bus();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) begin
      if (BYP && RegWrite && WriteRegister == i && i != 0)
        b[slice_base(i) +: 32] = WriteData;
      else
        b[slice_base(i) +: 32] = m_regs[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] exp_busyv();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic src_pending(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (BYP && RegWrite && WriteRegister == r) return 1'b0;
    return m_busy[r];
  endfunction

  function automatic logic exp_stall();
    return src_pending(ReadRegister1) | src_pending(ReadRegister2);
  endfunction

  task automatic idle_inputs();
    RegWrite = 1'b0;
    IssueValid = 1'b0;
  endtask

  // One clock with model update; returns at posedge+1 with write/issue deasserted.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    idle_inputs();
  endtask

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  id;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp_busy;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [8];

  initial begin
    model_clear();

    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h0000_0200, 1'b1};
    vecs[1] = '{1'b1, 5'd9,  32'hCAFE_0009, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 5'd4,  32'h0000_0444, 1'b1, 5'd4, 5'd4, 5'd0, 32'h0000_0010, 1'b1};
    vecs[3] = '{1'b1, 5'd6,  32'h0000_0666, 1'b1, 5'd3, 5'd6, 5'd0, 32'h0000_0018, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0000_0018, 1'b0};
    vecs[5] = '{1'b1, 5'd4,  32'h0000_4444, 1'b0, 5'd0, 5'd0, 5'd3, 32'h0000_0008, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h0000_0008, 1'b1};
    vecs[7] = '{1'b1, 5'd3,  32'h0000_3333, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0000_0000, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 1024'(Busy), 1024'(0));
    chk("reset_bus", RegBus, '0);
    chk("reset_stall", 1024'(Stall), 1024'(0));
    reset = 1'b0;

    // Directed scoreboard table.
    for (int n = 0; n < 8; n++) begin
      RegWrite = vecs[n].rw;
      WriteRegister = vecs[n].wr;
      WriteData = vecs[n].wd;
      IssueValid = vecs[n].iv;
      IssueDest = vecs[n].id;
      tick();
      ReadRegister1 = vecs[n].r1;
      ReadRegister2 = vecs[n].r2;
      #1;
      chk($sformatf("vec%0d_busy", n), 1024'(Busy), 1024'(vecs[n].exp_busy));
      chk($sformatf("vec%0d_stall", n), 1024'(Stall), 1024'(vecs[n].exp_stall));
      chk($sformatf("vec%0d_bus", n), RegBus, exp_bus());
    end
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Write reg 7, then check only slice 7 changed.
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h1234_5678;
    tick();
    #1;
    chk("wr7_slice", 1024'(RegBus[255:224]), 1024'(32'h1234_5678));
    chk("wr7_bus", RegBus, exp_bus());

    // Register 0 discards writes, even in the write cycle.
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
    #1;
    chk("wr0_same_cycle", 1024'(RegBus[31:0]), 1024'(0));
    tick();
    #1;
    chk("wr0_after", 1024'(RegBus[31:0]), 1024'(0));

    // Same-cycle visibility of a writeback.
    RegWrite = 1'b1; WriteRegister = 5'd12; WriteData = 32'hA5A5_A5A5;
    #1;
    chk("byp12_same_cycle", 1024'(RegBus[415:384]), 1024'(BYP ? 32'hA5A5_A5A5 : m_regs[12]));
    tick();
    #1;
    chk("byp12_next", 1024'(RegBus[415:384]), 1024'(32'hA5A5_A5A5));

    // Stall on a register being written back this cycle.
    IssueValid = 1'b1; IssueDest = 5'd15;
    tick();
    ReadRegister1 = 5'd15;
    RegWrite = 1'b1; WriteRegister = 5'd15; WriteData = 32'h0F0F_0F0F;
    #1;
    chk("wb_stall_same_cycle", 1024'(Stall), 1024'(BYP ? 1'b0 : 1'b1));
    tick();
    #1;
    chk("wb_stall_next", 1024'(Stall), 1024'(0));
    ReadRegister1 = '0;

    // Asynchronous reset mid-cycle.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEAD_BEEF;
    IssueValid = 1'b1; IssueDest = 5'd9;
    tick();
    #1;
    chk("pre_reset_r5", 1024'(RegBus[191:160]), 1024'(32'hDEAD_BEEF));
    chk("pre_reset_busy9", 1024'(Busy[9]), 1024'(1));
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    chk("async_reset_bus", RegBus, '0);
    chk("async_reset_busy", 1024'(Busy), 1024'(0));
    RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'h1111_1111;
    IssueValid = 1'b1; IssueDest = 5'd8;
    @(posedge clk);
    #1;
    chk("reset_hold_busy", 1024'(Busy), 1024'(0));
    chk("reset_hold_r8", 1024'(RegBus[287:256]), 1024'(0));
    idle_inputs();
    reset = 1'b0;

    // Randomised traffic checked against the model each cycle.
    for (int c = 0; c < 400; c++) begin
      RegWrite = ($urandom_range(0, 2) != 0);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      IssueValid = ($urandom_range(0, 1) != 0);
      IssueDest = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      chk($sformatf("rnd%0d_bus", c), RegBus, exp_bus());
      chk($sformatf("rnd%0d_busy", c), 1024'(Busy), 1024'(exp_busyv()));
      chk($sformatf("rnd%0d_stall", c), 1024'(Stall), 1024'(exp_stall()));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regbank_store.md
Name: regbank_store

Overview:
- Storage half of the register file: 32 x 32-bit architectural registers plus a pending-write scoreboard.
- Presents all register contents as one flattened 1024-bit bus. The 32-way per-bit read mux stage directly downstream consumes that bus and selects ReadData by ReadRegister.
- Accepts writeback from WB and tracks destinations issued but not yet written back.
- Raises a stall for ID when a source operand is still pending.

Parameters:
- DATA_WIDTH, 32, register width. The bus width is 32*DATA_WIDTH.
- ADDR_WIDTH, 5, register index width. The number of registers is 2**ADDR_WIDTH = 32.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero, never written and never busy.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- RegWrite  input  1  writeback enable from WB.
- WriteRegister  input  5  writeback destination index.
- WriteData  input  32  writeback value.
- IssueValid  input  1  an instruction with a register destination leaves ID this cycle.
- IssueDest  input  5  destination index of the issuing instruction.
- ReadRegister1  input  5  rs index, used for the stall check.
- ReadRegister2  input  5  rt index, used for the stall check.
- RegBus  output  1024  flattened contents; register i occupies bits [i*32+31 : i*32].
- Busy  output  32  pending-write bit per register.
- Stall  output  1  a source operand has a pending write.

Behaviour:
- Reset (asynchronous, active-high): all 32 registers go to 0 immediately, Busy = 0, Stall = 0. While reset is high, writes and issues are ignored.
- Write: on a rising edge with RegWrite=1 and WriteRegister=k, register k <= WriteData. RegBus shows the new value one cycle later. Exactly one register is written, selected by a one-hot 5-to-32 decode.
- Register 0 (ZERO_REG=1): writes are discarded, RegBus[31:0] is always 0, Busy[0] is always 0.
- Busy set: a rising edge with IssueValid=1 and IssueDest=k, k!=0, sets Busy[k].
- Busy clear: a rising edge with RegWrite=1 and WriteRegister=k clears Busy[k].
- Set and clear of the same k in the same cycle: set wins. Busy[k]=1 because a newer producer is in flight.
- Set and clear of different registers in the same cycle: both take effect.
- Repeated set of a register that is already busy: no change, and there is no counting. The pipeline guarantees in-order writeback.
- Stall (combinational) = Busy[ReadRegister1] | Busy[ReadRegister2]. Index 0 never stalls.
- Clear of a register that is not busy: it stays 0, with no error.
- Reset asserted mid-operation: all pending Busy bits are dropped. Writes landing on the same edge as reset release are lost.
- Latency: write-to-RegBus is 1 cycle. Busy-to-Stall is 0 cycles after the Busy update.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined:
  - RegBus slice k shows WriteData combinationally while RegWrite=1 and WriteRegister=k (k!=0), so a same-cycle read sees the writeback value.
  - Stall also treats a register being cleared this cycle as not busy.
  - Storage timing is unchanged.
- Undefined: pure registered outputs. The same-cycle read sees the old value and the stall persists one extra cycle.

Decomposition:
- Shared package regbank_pkg holds:
  - constants REG_COUNT=32, DATA_WIDTH=32, ADDR_WIDTH=5, BUS_WIDTH=1024, ZERO_IDX=0;
  - a function giving the slice base offset, idx*32.
- One sub-module, dec5to32: a 5-to-32 one-hot decoder with enable. Instantiated twice, once for the write decode and once for the issue decode.

Test Plan:
- Reset: assert reset mid-cycle after writing reg 5 = 0xDEADBEEF -> RegBus all 0 and Busy = 0 immediately, without waiting for a clock.
- Write/readback: write reg 7 = 0x12345678 -> next cycle RegBus[255:224] = 0x12345678 and all other slices unchanged. Write reg 0 = 0xFFFFFFFF -> RegBus[31:0] stays 0.
- Scoreboard: issue dest 9, then ReadRegister1=9 -> Stall=1. RegWrite reg 9 -> next cycle Busy[9]=0 and Stall=0.
- Simultaneous events:
  - Issue dest 4 and writeback reg 4 on the same edge -> Busy[4]=1.
  - Issue dest 3 with writeback reg 6 -> Busy[3]=1 and Busy[6]=0.
- Zero/no-stall: issue dest 0, ReadRegister1=ReadRegister2=0 -> Busy[0]=0 and Stall=0.
- Bypass (REGBANK_BYPASS_EN): RegWrite reg 12 = 0xA5A5A5A5 -> RegBus[415:384] = 0xA5A5A5A5 in the same cycle. Without the macro, it shows the old value until the next edge.
